mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter that shares the single-port `memory` block between the page-table walker (port 0) and a second client (port 1, e.g. the fetch/load path). It accepts one request at a time, forwards it over the memory valid/ready request channel, waits for the response and routes it back to the requester that owns the transaction. Round-robin fairness between the ports and a response timeout with error signalling are included.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `TIMEOUT_CYCLES`, 64, maximum cycles in WAIT_RESP before an error response; 0 disables the timeout
- `clk` in 1: single clock, all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `req0_valid_i` / `req1_valid_i` in 1: request from port 0 / port 1
- `req0_ready_o` / `req1_ready_o` out 1: request accepted this cycle
- `req0_addr_i` / `req1_addr_i` in ADDR_W: byte address
- `resp0_valid_o` / `resp1_valid_o` out 1: response valid for port 0 / port 1
- `resp0_ready_i` / `resp1_ready_i` in 1: requester accepts response
- `resp_data_o` out DATA_W: response data, shared by both ports, qualified by `respN_valid_o`
- `resp_err_o` out 1: response is a timeout error; data is 0
- `mem_req_valid_o` out 1, `mem_req_ready_i` in 1, `mem_addr_o` out ADDR_W: memory request channel
- `mem_resp_valid_i` in 1, `mem_resp_ready_o` out 1, `mem_data_i` in DATA_W: memory response channel

## Operation
- Handshake rule on every channel: a transfer happens at a rising edge where valid and ready are both 1. Once a valid is raised it is held, with stable payload, until the transfer.
- States: IDLE, ISSUE, WAIT_RESP, RESP.
- IDLE: if `stale_q`=0 and any `reqN_valid_i`, grant one port. `reqN_ready_o` is combinational: high only for the granted port, only in IDLE. On the transfer, latch the address and `owner_q`, then go to ISSUE.
- Arbitration: a single requester always wins. On a tie, the port other than `last_q` wins. `last_q` updates to the granted port at grant. Reset value is 1, so port 0 wins the first tie.
- ISSUE: `mem_req_valid_o`=1 and `mem_addr_o` equals the latched address. On `mem_req_ready_i`, go to WAIT_RESP and clear the timeout counter.
- WAIT_RESP: `mem_resp_ready_o`=1.
  - On `mem_resp_valid_i`: register `mem_data_i` into `resp_data_o`, set `resp_err_o`=0, go to RESP.
  - Otherwise increment the counter. If `TIMEOUT_CYCLES`≠0 and the counter reaches `TIMEOUT_CYCLES`: set `resp_data_o`=0, `resp_err_o`=1, set `stale_q`=1, go to RESP.
- RESP: `resp<owner>_valid_o`=1 and the other port's valid is 0. Data and err are held. On the owner's `respN_ready_i`, go to IDLE.
- Stale drain: while `stale_q`=1 in RESP or IDLE, `mem_resp_ready_o`=1. The first `mem_resp_valid_i` is discarded and clears `stale_q`. No grant is made while `stale_q`=1.
- `mem_req_valid_o` is 0 outside ISSUE. `mem_resp_ready_o` is 0 outside WAIT_RESP, except during a stale drain.
- Reset, including mid-transaction: state goes to IDLE, `stale_q`=0, `last_q`=1, counter 0. Any in-flight transaction is abandoned.

## Timing
- Reset values:
  - All valid/ready outputs 0, except that `reqN_ready_o` may go high combinationally in IDLE.
  - `resp_data_o`=0, `resp_err_o`=0, `mem_addr_o`=0.
- Grant at edge T puts the request on the memory channel at T+1 (ISSUE).
- A memory response accepted at edge R makes `respN_valid_o` high from R+1.
- Latency, requester accept to response valid: 2 cycles plus memory request wait plus memory response latency.
- Throughput: one transaction in flight. The next grant is possible in the cycle after the response transfer.
- A timeout response appears in the cycle after the counter reaches `TIMEOUT_CYCLES`.
- Requests that arrive while the arbiter is busy are simply not readied. No queuing.

## Test plan
- **Single port 0 read:** after reset, port 0 reads 0x400 -> `resp0_valid_o` with data 0x00000801, `resp_err_o`=0, `resp1_valid_o` stays 0. Port 1 reads 0x800 -> `resp1_valid_o` with data 0x1000000F.
- **Simultaneous requests:** first tie after reset (port 0 reads 0x400, port 1 reads 0x404) -> port 0 granted first and gets 0x00000801, then port 1 gets 0x12340000. Second tie -> port 1 granted first.
- **Response back-pressure:** hold `resp0_ready_i`=0 for 10 cycles -> `resp0_valid_o` and data 0x1100000F (addr 0x804) stay stable, no new grant to port 1 until the accept.
- **Out of range:** read 0x1000 -> data 0x00000000, `resp_err_o`=0.
- **Timeout:** use a memory stub that never responds, with `TIMEOUT_CYCLES`=8 -> error response with data 0 and `resp_err_o`=1. A late stub response is discarded, then the next request completes normally.
- **Reset mid-operation:** assert `rst` for 1 cycle while in WAIT_RESP -> all outputs return to reset values, no response is delivered, and the next port 0 read of 0x808 returns 0x12000007.

Source files
------------

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one single-port memory between two requesters.
// Port 0 is the page-table walker, port 1 a second client (fetch/load).
// One transaction is in flight at a time; ties are broken round-robin, and
// a memory response that never arrives is turned into an error response
// after TIMEOUT_CYCLES cycles (0 disables the timeout).
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid_i/ready_o/addr_i   request channel of port N (N = 0, 1)
//   respN_valid_o/ready_i         response channel of port N
//   resp_data_o, resp_err_o       shared response payload (err => data 0)
//   mem_req_valid_o/ready_i       memory request channel, addr on mem_addr_o
//   mem_resp_valid_i/ready_o      memory response channel, data on mem_data_i
module mem_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid_i,
  output logic              req0_ready_o,
  input  logic [ADDR_W-1:0] req0_addr_i,
  input  logic              req1_valid_i,
  output logic              req1_ready_o,
  input  logic [ADDR_W-1:0] req1_addr_i,
  output logic              resp0_valid_o,
  input  logic              resp0_ready_i,
  output logic              resp1_valid_o,
  input  logic              resp1_ready_i,
  output logic [DATA_W-1:0] resp_data_o,
  output logic              resp_err_o,
  output logic              mem_req_valid_o,
  input  logic              mem_req_ready_i,
  output logic [ADDR_W-1:0] mem_addr_o,
  input  logic              mem_resp_valid_i,
  output logic              mem_resp_ready_o,
  input  logic [DATA_W-1:0] mem_data_i
);

  localparam int CNT_W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RESP, RESP} state_t;

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              owner_q, owner_d;
  logic              last_q, last_d;
  logic              stale_q, stale_d;
  logic              err_q, err_d;
  logic              grant0, grant1;

  // A lone requester always wins; on a tie the port that was not granted
  // last time wins.
  always_comb begin
    grant0 = req0_valid_i && (!req1_valid_i || last_q);
    grant1 = req1_valid_i && (!req0_valid_i || !last_q);
  end

  always_comb begin
    state_d          = state_q;
    addr_d           = addr_q;
    data_d           = data_q;
    cnt_d            = cnt_q;
    owner_d          = owner_q;
    last_d           = last_q;
    stale_d          = stale_q;
    err_d            = err_q;
    req0_ready_o     = 1'b0;
    req1_ready_o     = 1'b0;
    mem_req_valid_o  = 1'b0;
    mem_resp_ready_o = 1'b0;
    resp0_valid_o    = 1'b0;
    resp1_valid_o    = 1'b0;

    // After a timeout the memory still owes one response; swallow it
    // before any new request may be issued.
    if (stale_q && (state_q == IDLE || state_q == RESP)) begin
      mem_resp_ready_o = 1'b1;
      if (mem_resp_valid_i) stale_d = 1'b0;
    end

    case (state_q)
      IDLE: begin
        if (!stale_q) begin
          req0_ready_o = grant0;
          req1_ready_o = grant1;
          if (grant0 || grant1) begin
            addr_d  = grant1 ? req1_addr_i : req0_addr_i;
            owner_d = grant1;
            last_d  = grant1;
            state_d = ISSUE;
          end
        end
      end
      ISSUE: begin
        mem_req_valid_o = 1'b1;
        if (mem_req_ready_i) begin
          cnt_d   = '0;
          state_d = WAIT_RESP;
        end
      end
      WAIT_RESP: begin
        mem_resp_ready_o = 1'b1;
        if (mem_resp_valid_i) begin
          data_d  = mem_data_i;
          err_d   = 1'b0;
          state_d = RESP;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (TIMEOUT_CYCLES != 0 && cnt_d == CNT_LIMIT) begin
            data_d  = '0;
            err_d   = 1'b1;
            stale_d = 1'b1;
            state_d = RESP;
          end
        end
      end
      RESP: begin
        resp0_valid_o = !owner_q;
        resp1_valid_o = owner_q;
        if (owner_q ? resp1_ready_i : resp0_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      addr_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      stale_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      stale_q <= stale_d;
      err_q   <= err_d;
    end
  end

  assign mem_addr_o  = addr_q;
  assign resp_data_o = data_q;
  assign resp_err_o  = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed and randomized bench for mem_arbiter.
// The bench plays both requesters and the memory; a small model tracks the
// round-robin history, the memory contents and the stale-response state.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic          req0_valid_i, req1_valid_i, req0_ready_o, req1_ready_o;
  logic [AW-1:0] req0_addr_i, req1_addr_i;
  logic          resp0_valid_o, resp1_valid_o, resp0_ready_i, resp1_ready_i;
  logic [DW-1:0] resp_data_o;
  logic          resp_err_o;
  logic          mem_req_valid_o, mem_req_ready_i;
  logic [AW-1:0] mem_addr_o;
  logic          mem_resp_valid_i, mem_resp_ready_o;
  logic [DW-1:0] mem_data_i;

  int checks = 0;
  int errors = 0;
  logic m_last;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .req0_valid_i(req0_valid_i), .req0_ready_o(req0_ready_o), .req0_addr_i(req0_addr_i),
    .req1_valid_i(req1_valid_i), .req1_ready_o(req1_ready_o), .req1_addr_i(req1_addr_i),
    .resp0_valid_o(resp0_valid_o), .resp0_ready_i(resp0_ready_i),
    .resp1_valid_o(resp1_valid_o), .resp1_ready_i(resp1_ready_i),
    .resp_data_o(resp_data_o), .resp_err_o(resp_err_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i), .mem_addr_o(mem_addr_o),
    .mem_resp_valid_i(mem_resp_valid_i), .mem_resp_ready_o(mem_resp_ready_o), .mem_data_i(mem_data_i)
  );

  // Memory contents: a few fixed words, a hashed pattern elsewhere below
  // 0x1000, zero above.
  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h400: return 32'h0000_0801;
      32'h404: return 32'h1234_0000;
      32'h800: return 32'h1000_000F;
      32'h804: return 32'h1100_000F;
      32'h808: return 32'h1200_0007;
      default: return (a >= 32'h1000) ? 32'h0 : {a[15:0] ^ 16'h5A5A, ~a[15:0]};
    endcase
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int predict();
    if (req0_valid_i && req1_valid_i) return m_last ? 0 : 1;
    return req0_valid_i ? 0 : 1;
  endfunction

  // One complete transaction for whichever port the model says wins.
  task automatic serve(input int req_wait, input int resp_lat, input int bp, input bit raise_other);
    int p;
    logic [31:0] a, d;
    logic [1:0] onehot;
    #1;
    p = predict();
    a = (p == 1) ? req1_addr_i : req0_addr_i;
    d = mem_word(a);
    onehot = (p == 1) ? 2'b10 : 2'b01;
    m_last = p[0];
    chk("grant", {req1_ready_o, req0_ready_o}, onehot);
    step();
    if (p == 1) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
    if (raise_other) begin
      if (p == 1) req0_valid_i = 1'b1; else req1_valid_i = 1'b1;
    end
    #1;
    chk("issue_valid", mem_req_valid_o, 1);
    chk("issue_addr", mem_addr_o, a);
    chk("busy_no_ready", {req1_ready_o, req0_ready_o}, 0);
    repeat (req_wait) step();
    chk("issue_hold", {mem_req_valid_o, mem_addr_o}, {1'b1, a});
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    chk("req_dropped", mem_req_valid_o, 0);
    chk("wait_resp_ready", mem_resp_ready_o, 1);
    repeat (resp_lat) step();
    chk("no_early_resp", {resp1_valid_o, resp0_valid_o}, 0);
    mem_resp_valid_i = 1'b1;
    mem_data_i = d;
    step();
    mem_resp_valid_i = 1'b0;
    mem_data_i = $urandom();
    chk("resp_valid", {resp1_valid_o, resp0_valid_o}, onehot);
    chk("resp_data", resp_data_o, d);
    chk("resp_err", resp_err_o, 0);
    if (bp > 0) begin
      if (p == 1) resp0_ready_i = 1'b1; else resp1_ready_i = 1'b1;
      repeat (bp) step();
      resp0_ready_i = 1'b0;
      resp1_ready_i = 1'b0;
      chk("bp_hold", {resp1_valid_o, resp0_valid_o, resp_err_o, resp_data_o}, {onehot, 1'b0, d});
      chk("bp_no_grant", {req1_ready_o, req0_ready_o}, 0);
      chk("bp_mem_quiet", {mem_req_valid_o, mem_resp_ready_o}, 0);
    end
    if (p == 1) resp1_ready_i = 1'b1; else resp0_ready_i = 1'b1;
    step();
    resp0_ready_i = 1'b0;
    resp1_ready_i = 1'b0;
    chk("resp_done", {resp1_valid_o, resp0_valid_o}, 0);
  endtask

  task automatic serve_timeout();
    int p, n;
    logic [1:0] onehot;
    #1;
    p = predict();
    onehot = (p == 1) ? 2'b10 : 2'b01;
    m_last = p[0];
    chk("to_grant", {req1_ready_o, req0_ready_o}, onehot);
    step();
    if (p == 1) req1_valid_i = 1'b0; else req0_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    n = 0;
    while (!(resp0_valid_o || resp1_valid_o) && n < 4 * TO) begin
      step();
      n++;
    end
    chk("to_cycles", n, TO);
    chk("to_owner", {resp1_valid_o, resp0_valid_o}, onehot);
    chk("to_data", resp_data_o, 0);
    chk("to_err", resp_err_o, 1);
    chk("to_drain_ready", mem_resp_ready_o, 1);
    if (p == 1) resp1_ready_i = 1'b1; else resp0_ready_i = 1'b1;
    step();
    resp0_ready_i = 1'b0;
    resp1_ready_i = 1'b0;
    chk("to_done", {resp1_valid_o, resp0_valid_o}, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before 1ms");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    req0_valid_i = 1'b0; req1_valid_i = 1'b0;
    req0_addr_i = '0; req1_addr_i = '0;
    resp0_ready_i = 1'b0; resp1_ready_i = 1'b0;
    mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_data_i = '0;
    m_last = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    chk("reset_ctrl", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
                       mem_req_valid_o, mem_resp_ready_o, resp_err_o}, 0);
    chk("reset_data", resp_data_o, 0);
    chk("reset_addr", mem_addr_o, 0);

    // First tie after reset: port 0 then port 1.
    req0_addr_i = 32'h400; req1_addr_i = 32'h404;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    serve(0, 0, 0, 0);
    serve(1, 2, 0, 0);

    // Singles, leaving port 0 as the last winner.
    req1_addr_i = 32'h800; req1_valid_i = 1'b1;
    serve(2, 1, 0, 0);
    req0_addr_i = 32'h400; req0_valid_i = 1'b1;
    serve(0, 3, 0, 0);

    // Second tie: port 1 first. Port 0 reads out of range.
    req0_addr_i = 32'h1000; req1_addr_i = 32'h808;
    req0_valid_i = 1'b1; req1_valid_i = 1'b1;
    serve(0, 0, 0, 0);
    serve(1, 1, 0, 0);

    // Back-pressure with port 1 waiting behind.
    req0_addr_i = 32'h804; req1_addr_i = 32'h400; req0_valid_i = 1'b1;
    serve(0, 1, 10, 1);
    serve(0, 0, 0, 0);

    // Timeout, stale drain, then a normal read.
    req1_addr_i = 32'h808; req1_valid_i = 1'b1;
    serve_timeout();
    req0_addr_i = 32'h400; req0_valid_i = 1'b1;
    #1;
    chk("stale_no_grant", {req1_ready_o, req0_ready_o}, 0);
    chk("stale_drain_ready", mem_resp_ready_o, 1);
    step(); step();
    chk("stale_still_blocked", {req1_ready_o, req0_ready_o, mem_req_valid_o}, 0);
    mem_resp_valid_i = 1'b1; mem_data_i = 32'hDEAD_BEEF;
    step();
    mem_resp_valid_i = 1'b0;
    #1;
    chk("stale_cleared", mem_resp_ready_o, 0);
    chk("stale_data_dropped", {resp1_valid_o, resp0_valid_o, resp_data_o}, 0);
    serve(0, 1, 0, 0);

    // Reset while waiting for the memory response.
    req0_addr_i = 32'h404; req0_valid_i = 1'b1;
    #1;
    chk("mid_grant", {req1_ready_o, req0_ready_o}, 2'b01);
    step();
    req0_valid_i = 1'b0;
    mem_req_ready_i = 1'b1;
    step();
    mem_req_ready_i = 1'b0;
    step();
    chk("mid_waiting", mem_resp_ready_o, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    m_last = 1'b1;
    chk("mid_reset_ctrl", {req0_ready_o, req1_ready_o, resp0_valid_o, resp1_valid_o,
                           mem_req_valid_o, mem_resp_ready_o, resp_err_o}, 0);
    chk("mid_reset_data", resp_data_o, 0);
    chk("mid_reset_addr", mem_addr_o, 0);
    step(); step(); step();
    chk("mid_no_resp", {resp1_valid_o, resp0_valid_o, mem_resp_ready_o}, 0);
    req0_addr_i = 32'h808; req0_valid_i = 1'b1;
    serve(0, 2, 0, 0);

    // Randomized traffic.
    for (int i = 0; i < 40; i++) begin
      int pat;
      pat = int'($urandom_range(1, 3));
      req0_addr_i = $urandom_range(0, 32'h17FF) & 32'hFFFF_FFFC;
      req1_addr_i = $urandom_range(0, 32'h17FF) & 32'hFFFF_FFFC;
      req0_valid_i = pat[0];
      req1_valid_i = pat[1];
      while (req0_valid_i || req1_valid_i)
        serve(int'($urandom_range(0, 3)), int'($urandom_range(0, 4)),
              int'($urandom_range(0, 3)), 1'b0);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
